// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential/redirect selection, interrupt
// entry with EPC save, handler return, and boot-vector choice after reset.
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] STEP       = WIDTH'(1),
  parameter logic [WIDTH-1:0] BOOT_VEC_A = WIDTH'(0),
  parameter logic [WIDTH-1:0] BOOT_VEC_B = WIDTH'(15),
  parameter logic [WIDTH-1:0] IRQ_VEC    = WIDTH'(4)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             progr,
  input  logic             stall,
  input  logic [1:0]       next_sel,
  input  logic [WIDTH-1:0] target,
  input  logic             interrupt,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             in_handler,
  output logic             irq_ack
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic             pend_q;
  logic             irq_q;
  logic             ack_q;
  logic [WIDTH-1:0] seq_d;
  logic             irq_edge;
  logic             irq_req;

  assign irq_edge = interrupt & ~irq_q;
  assign irq_req  = irq_edge | pend_q;

  always_comb begin
    seq_d = pc_q;
    unique case (next_sel)
      2'b00:        seq_d = pc_q + STEP;
      2'b01, 2'b10: seq_d = target;
      default:      seq_d = pc_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= '0;
      epc_q   <= '0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      irq_q <= interrupt;
      ack_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          pc_q    <= progr ? BOOT_VEC_B : BOOT_VEC_A;
          state_q <= RUN;
          if (irq_edge) pend_q <= 1'b1;
        end
        RUN: begin
          if (stall) begin
            if (irq_edge) pend_q <= 1'b1;
          end else if (irq_req) begin
            epc_q   <= seq_d;
            pc_q    <= IRQ_VEC;
            ack_q   <= 1'b1;
            // a fresh edge arriving while an older one is consumed stays queued
            pend_q  <= pend_q & irq_edge;
            state_q <= HANDLER;
          end else begin
            pc_q <= seq_d;
          end
        end
        HANDLER: begin
          if (irq_edge) pend_q <= 1'b1;
          if (!stall) begin
            if (eret) begin
              pc_q    <= epc_q;
              state_q <= RUN;
            end else begin
              pc_q <= seq_d;
            end
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign irq_ack    = ack_q;
  assign in_handler = (state_q == HANDLER);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with constant
// expectations, then random stimulus against a behavioural model.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        progr = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  next_sel = 2'b00;
  logic [31:0] target = '0;
  logic        interrupt = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        in_handler;
  logic        irq_ack;

  int total = 0;
  int bad = 0;

  // model: mode 0 boot, 1 running, 2 inside handler
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  logic        m_pend, m_prev, m_ack;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .progr(progr), .stall(stall),
    .next_sel(next_sel), .target(target), .interrupt(interrupt),
    .eret(eret), .pc(pc), .epc(epc), .in_handler(in_handler),
    .irq_ack(irq_ack)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_mode = 0; m_pc = '0; m_epc = '0;
    m_pend = 1'b0; m_prev = 1'b0; m_ack = 1'b0;
  endtask

  task automatic model_step();
    logic        rise;
    logic [31:0] nxt;
    rise = interrupt && !m_prev;
    if (next_sel == 2'd0) nxt = m_pc + 32'd1;
    else if (next_sel == 2'd3) nxt = m_pc;
    else nxt = target;
    m_ack = 1'b0;
    if (m_mode == 0) begin
      m_pc = progr ? 32'd15 : 32'd0;
      m_mode = 1;
      m_pend = m_pend || rise;
    end else if (stall) begin
      m_pend = m_pend || rise;
    end else if (m_mode == 1) begin
      if (rise || m_pend) begin
        m_epc = nxt; m_pc = 32'd4; m_ack = 1'b1;
        m_pend = m_pend && rise;
        m_mode = 2;
      end else m_pc = nxt;
    end else begin
      m_pend = m_pend || rise;
      if (eret) begin m_pc = m_epc; m_mode = 1; end
      else m_pc = nxt;
    end
    m_prev = interrupt;
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic jump_to(input logic [31:0] a);
    next_sel = 2'b10; target = a;
    tick();
    next_sel = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0; progr = 1'b1;
    #2; model_reset();
    total++; if (pc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", pc); end
    total++; if ({epc, in_handler, irq_ack} !== 34'd0) begin bad++; $display("FAIL rst_outs epc=%0h h=%b ack=%b", epc, in_handler, irq_ack); end
    tick();
    reset = 1'b1;
    tick();
    total++; if (pc !== 32'd15) begin bad++; $display("FAIL boot_b got=%0h exp=f", pc); end
    next_sel = 2'b00;
    tick();
    total++; if (pc !== 32'd16) begin bad++; $display("FAIL boot_run got=%0h exp=10", pc); end
    reset = 1'b0; progr = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    total++; if (pc !== 32'd0) begin bad++; $display("FAIL boot_a got=%0h exp=0", pc); end
  endtask

  task automatic test_wrap_stall();
    jump_to(32'hFFFF_FFFF);
    total++; if (pc !== 32'hFFFF_FFFF) begin bad++; $display("FAIL jump got=%0h exp=ffffffff", pc); end
    tick();
    total++; if (pc !== 32'd0) begin bad++; $display("FAIL wrap got=%0h exp=0", pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== 32'd0) begin bad++; $display("FAIL stall%0d got=%0h exp=0", i, pc); end
    end
    stall = 1'b0;
    next_sel = 2'b01; target = 32'd77;
    tick();
    total++; if (pc !== 32'd77) begin bad++; $display("FAIL branch got=%0h exp=4d", pc); end
    next_sel = 2'b11;
    tick();
    total++; if (pc !== 32'd77) begin bad++; $display("FAIL hold got=%0h exp=4d", pc); end
    next_sel = 2'b00;
  endtask

  task automatic test_irq_eret();
    jump_to(32'd20);
    interrupt = 1'b1;
    tick();
    total++; if ({pc, epc} !== {32'd4, 32'd21}) begin bad++; $display("FAIL entry pc=%0h epc=%0h exp=4/15", pc, epc); end
    total++; if ({irq_ack, in_handler} !== 2'b11) begin bad++; $display("FAIL entry_flags ack=%b h=%b exp=1/1", irq_ack, in_handler); end
    interrupt = 1'b0;
    tick();
    total++; if ({pc, irq_ack} !== {32'd5, 1'b0}) begin bad++; $display("FAIL ack_pulse pc=%0h ack=%b exp=5/0", pc, irq_ack); end
    tick();
    eret = 1'b1; next_sel = 2'b10; target = 32'd99;
    tick();
    eret = 1'b0; next_sel = 2'b00;
    total++; if ({pc, in_handler} !== {32'd21, 1'b0}) begin bad++; $display("FAIL eret pc=%0h h=%b exp=15/0", pc, in_handler); end
  endtask

  task automatic test_nested();
    jump_to(32'd20);
    interrupt = 1'b1; tick();
    interrupt = 1'b0; tick();
    interrupt = 1'b1; tick();
    total++; if ({pc, irq_ack, in_handler} !== {32'd6, 1'b0, 1'b1}) begin bad++; $display("FAIL no_nest pc=%0h ack=%b h=%b", pc, irq_ack, in_handler); end
    interrupt = 1'b0; eret = 1'b1; tick();
    eret = 1'b0;
    total++; if ({pc, in_handler} !== {32'd21, 1'b0}) begin bad++; $display("FAIL nest_eret pc=%0h h=%b exp=15/0", pc, in_handler); end
    tick();
    total++; if ({pc, epc, irq_ack} !== {32'd4, 32'd22, 1'b1}) begin bad++; $display("FAIL reentry pc=%0h epc=%0h ack=%b", pc, epc, irq_ack); end
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_stall_irq();
    jump_to(32'd40);
    stall = 1'b1; interrupt = 1'b1; tick();
    interrupt = 1'b0; tick();
    total++; if ({pc, in_handler} !== {32'd40, 1'b0}) begin bad++; $display("FAIL stall_irq pc=%0h h=%b exp=28/0", pc, in_handler); end
    stall = 1'b0; tick();
    total++; if ({pc, epc, irq_ack} !== {32'd4, 32'd41, 1'b1}) begin bad++; $display("FAIL stall_entry pc=%0h epc=%0h ack=%b", pc, epc, irq_ack); end
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_async_reset();
    jump_to(32'd50);
    interrupt = 1'b1; tick();
    interrupt = 1'b0; tick();
    interrupt = 1'b1; tick();
    interrupt = 1'b0;
    #2; reset = 1'b0; #1; model_reset();
    total++; if ({pc, epc, in_handler, irq_ack} !== 66'd0) begin bad++; $display("FAIL async_rst pc=%0h epc=%0h h=%b", pc, epc, in_handler); end
    tick(); reset = 1'b1; progr = 1'b0;
    tick(); tick(); tick();
    total++; if ({pc, in_handler} !== {32'd2, 1'b0}) begin bad++; $display("FAIL no_spurious pc=%0h h=%b exp=2/0", pc, in_handler); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      next_sel = 2'($urandom_range(0, 3));
      target   = $urandom;
      if ($urandom_range(0, 2) == 0) interrupt = ~interrupt;
      eret     = ($urandom_range(0, 4) == 0);
      progr    = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 99) != 0);
      tick();
      total++;
      if ({pc, epc, in_handler, irq_ack} !== {m_pc, m_epc, (m_mode == 2), m_ack}) begin
        bad++;
        $display("FAIL rand%0d pc=%0h/%0h epc=%0h/%0h h=%b/%b ack=%b/%b", i,
                 pc, m_pc, epc, m_epc, in_handler, (m_mode == 2), irq_ack, m_ack);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap_stall();
    test_irq_eret();
    test_nested();
    test_stall_irq();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS core fetch stage. It holds the fetch PC and selects the next value from sequential increment, branch/jump target, interrupt vector or exception return. It latches interrupt edges, saves the return address in an EPC register, and chooses one of two boot vectors after reset. It drives instruction memory directly and takes its redirect controls from decode/execute.

## Interface
- WIDTH, 32, PC/EPC/target width in bits
- STEP, 1, sequential increment (word-addressed memory)
- BOOT_VEC_A, 0, boot PC when progr=0
- BOOT_VEC_B, 15, boot PC when progr=1
- IRQ_VEC, 4, interrupt handler entry PC

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- progr  in  1  boot-vector select, sampled in BOOT
- stall  in  1  1 = hold PC and EPC, block interrupt entry and eret
- next_sel  in  2  00 sequential, 01 branch, 10 jump, 11 hold
- target  in  WIDTH  branch/jump destination
- interrupt  in  1  interrupt request, level input, rising edge detected
- eret  in  1  return from handler
- pc  out  WIDTH  current fetch PC (registered)
- epc  out  WIDTH  saved return PC (registered)
- in_handler  out  1  1 while in HANDLER state
- irq_ack  out  1  one-cycle pulse on handler entry

## Operation
- Reset (reset=0): state=BOOT; pc=0, epc=0, in_handler=0, irq_ack=0, pending=0, irq_q=0.
- States: BOOT, RUN, HANDLER. Encoding is free.
- irq_edge = interrupt & ~irq_q, where irq_q is interrupt registered every cycle in every state. irq_req = irq_edge | pending.
- seq_next: sel 00 gives pc+STEP mod 2^WIDTH (wraps silently). Sel 01 and 10 give target. Sel 11 gives pc.
- BOOT: the next posedge loads pc = progr ? BOOT_VEC_B : BOOT_VEC_A, then the state moves to RUN. BOOT ignores stall, next_sel and eret. An irq_edge in BOOT sets pending.
- RUN, priority high to low:
  1. stall=1: all registers hold; irq_edge sets pending.
  2. irq_req=1: epc=seq_next, pc=IRQ_VEC, irq_ack=1 for one cycle, pending=0, state=HANDLER.
  3. Otherwise pc=seq_next. In RUN, eret is ignored (pc still follows next_sel).
- HANDLER, priority high to low:
  1. stall=1: all registers hold; irq_edge sets pending.
  2. eret=1: pc=epc, state=RUN. next_sel is ignored that cycle.
  3. Otherwise pc=seq_next. Interrupts do not nest: irq_edge sets pending, which is serviced on the first unstalled RUN cycle after eret.
- Same-cycle events:
  - A new irq_edge on the cycle pending is consumed by entry leaves pending=1.
  - eret and irq_edge together: eret executes and pending=1.
- epc changes only on handler entry. in_handler=1 exactly when state=HANDLER.
- Reset asserted mid-handler or mid-stall returns everything to reset values asynchronously. Pending interrupts are lost.

## Timing
- All outputs are registered; no combinational path from input to output.
- Boot: the first posedge after reset deasserts loads the boot vector, so pc is valid one cycle after release.
- Interrupt latency: a rising edge sampled at posedge k (RUN, stall=0) gives pc=IRQ_VEC and irq_ack=1 after posedge k. A stall delays entry to the first unstalled posedge.
- eret: pc=epc after the posedge that samples eret=1.
- Redirect: target appears on pc one cycle after it is sampled.

## Test plan
- Reset, release with progr=1 → pc=0 during reset, pc=15 after the first clock, state RUN. Repeat with progr=0 → pc=0.
- WIDTH=32, pc forced to 0xFFFFFFFF via jump target, sel=00 → next pc=0x00000000. A stall asserted for 3 cycles → pc constant for 3 cycles.
- pc=20, sel=00, interrupt pulse → epc=21, pc=4, irq_ack high for 1 cycle, in_handler=1. After 2 sequential cycles (pc=6), eret → pc=21, in_handler=0.
- Second interrupt edge while in HANDLER → no entry. After eret, the next unstalled cycle enters the handler again (pc=4, irq_ack=1).
- Interrupt edge while stall=1 in RUN → pending held, pc unchanged. On stall release, handler entered with epc=seq_next of that cycle.
- reset low while in HANDLER with pending=1 → pc=0, epc=0, in_handler=0 immediately (asynchronously). After release, no spurious interrupt entry.
